// File: rtl/anim_tick_gen.sv
// Slow animation clock generator with a selectable rate and run/pause and single-step pushbuttons.
// Keys are synchronised and debounced locally; o_tick strobes on every rising edge of o_clk_slow.
module anim_tick_gen #(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned BASE_HZ    = 1,
   parameter int unsigned DEB_CYCLES = 500_000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_key_run,
   input  logic       i_key_step,
   input  logic [1:0] i_rate_sel,
   output logic       o_clk_slow,
   output logic       o_tick,
   output logic       o_running
);

   localparam int unsigned HalfBase = CLK_HZ / (2 * BASE_HZ);
   localparam int unsigned CntW     = (HalfBase > 1) ? $clog2(HalfBase) : 1;
   localparam int unsigned DebW     = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;

   localparam logic [CntW-1:0] HalfM1R0 = CntW'(HalfBase - 1);
   localparam logic [CntW-1:0] HalfM1R1 = CntW'((HalfBase >> 1) - 1);
   localparam logic [CntW-1:0] HalfM1R2 = CntW'((HalfBase >> 2) - 1);
   localparam logic [CntW-1:0] HalfM1R3 = CntW'((HalfBase >> 3) - 1);
   localparam logic [DebW-1:0] DebLast  = DebW'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      StRun,
      StStopping,
      StStopped,
      StStep
   } state_e;

   // Key pipeline, bit 0 = run key, bit 1 = step key; all levels active-low.
   logic [1:0]      w_key_raw;
   logic [1:0]      r_sync0;
   logic [1:0]      r_sync1;
   logic [1:0]      r_stable;
   logic [1:0]      r_press;
   logic [DebW-1:0] r_deb_cnt [2];
   logic            w_run_press;
   logic            w_step_press;

   state_e          r_state;
   logic [CntW-1:0] r_cnt;
   logic [1:0]      r_rate;
   logic            r_clk_slow;
   logic            r_tick;
   logic            r_running;
   logic [CntW-1:0] w_half_m1;
   logic            w_wrap;

   assign w_key_raw    = {i_key_step, i_key_run};
   assign w_run_press  = r_press[0];
   assign w_step_press = r_press[1];

   // A differing level must persist for DEB_CYCLES samples before it replaces the stable level.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync0  <= 2'b11;
         r_sync1  <= 2'b11;
         r_stable <= 2'b11;
         r_press  <= 2'b00;
         for (int k = 0; k < 2; k++) begin
            r_deb_cnt[k] <= '0;
         end
      end else begin
         r_sync0 <= w_key_raw;
         r_sync1 <= r_sync0;
         for (int k = 0; k < 2; k++) begin
            r_press[k] <= 1'b0;
            if (r_sync1[k] == r_stable[k]) begin
               r_deb_cnt[k] <= '0;
            end else if (r_deb_cnt[k] == DebLast) begin
               r_deb_cnt[k] <= '0;
               r_stable[k]  <= r_sync1[k];
               r_press[k]   <= ~r_sync1[k];
            end else begin
               r_deb_cnt[k] <= r_deb_cnt[k] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_half_m1 = HalfM1R0;
      unique case (r_rate)
         2'd0: w_half_m1 = HalfM1R0;
         2'd1: w_half_m1 = HalfM1R1;
         2'd2: w_half_m1 = HalfM1R2;
         2'd3: w_half_m1 = HalfM1R3;
         default: w_half_m1 = HalfM1R0;
      endcase
   end

   assign w_wrap = (r_cnt == w_half_m1);

   // Run press has priority over step press wherever both are meaningful.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= StRun;
         r_cnt      <= '0;
         r_rate     <= i_rate_sel;
         r_clk_slow <= 1'b0;
         r_tick     <= 1'b0;
         r_running  <= 1'b1;
      end else begin
         r_tick <= 1'b0;
         unique case (r_state)
            StRun, StStopping: begin
               if (w_wrap) begin
                  r_cnt      <= '0;
                  r_clk_slow <= ~r_clk_slow;
                  r_tick     <= ~r_clk_slow;
                  // Rate only changes on a falling toggle so no period is cut short.
                  if (r_clk_slow) begin
                     r_rate <= i_rate_sel;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
               if (r_state == StRun) begin
                  if (w_run_press) begin
                     r_state <= StStopping;
                  end
               end else if (w_run_press) begin
                  r_state <= StRun;
               end else if (w_wrap && r_clk_slow) begin
                  r_state   <= StStopped;
                  r_running <= 1'b0;
               end
            end
            StStopped: begin
               r_cnt      <= '0;
               r_clk_slow <= 1'b0;
               if (w_run_press) begin
                  r_state   <= StRun;
                  r_running <= 1'b1;
               end else if (w_step_press) begin
                  r_state    <= StStep;
                  r_clk_slow <= 1'b1;
                  r_tick     <= 1'b1;
               end
            end
            StStep: begin
               if (w_wrap) begin
                  r_cnt      <= '0;
                  r_clk_slow <= 1'b0;
                  r_rate     <= i_rate_sel;
                  r_state    <= StStopped;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= StRun;
            end
         endcase
      end
   end

   assign o_clk_slow = r_clk_slow;
   assign o_tick     = r_tick;
   assign o_running  = r_running;

endmodule

// File: tb/tb_anim_tick_gen.sv
// Bench for anim_tick_gen: expected tick cycles are queued as stimulus is driven and popped by a
// monitor on every observed tick; output levels are also checked at chosen cycles.
module tb_anim_tick_gen;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       key_run  = 1'b1;
   logic       key_step = 1'b1;
   logic [1:0] rate_sel = 2'd0;
   logic       clk_slow;
   logic       tick;
   logic       running;

   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   exp_q[$];
   logic prev_slow = 1'b0;

   anim_tick_gen #(
      .CLK_HZ    (16),
      .BASE_HZ   (1),
      .DEB_CYCLES(4)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_key_run (key_run),
      .i_key_step(key_step),
      .i_rate_sel(rate_sel),
      .o_clk_slow(clk_slow),
      .o_tick    (tick),
      .o_running (running)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int expv);
      n_cmp++;
      if (obs != expv) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // Every tick must coincide with a rise of clk_slow and land on the next queued cycle.
   always @(negedge clk) begin
      chk("tick_on_rise", int'(tick), int'(clk_slow && !prev_slow));
      prev_slow = clk_slow;
      if (tick) begin
         if (exp_q.size() == 0) begin
            chk("tick_unexpected", cyc, -1);
         end else begin
            chk("tick_cycle", cyc, exp_q.pop_front());
         end
      end
   end

   task automatic wait_to(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic expect_at(input string tag, input int t, input int slow, input int run);
      wait_to(t);
      chk({tag, "_slow"}, int'(clk_slow), slow);
      chk({tag, "_running"}, int'(running), run);
   endtask

   initial begin
      int c, d, e, f, g, h;
      repeat (3) @(negedge clk);
      chk("rst_slow", int'(clk_slow), 0);
      chk("rst_tick", int'(tick), 0);
      chk("rst_running", int'(running), 1);

      // 1: base rate after reset release
      c = cyc;
      exp_q.push_back(c + 8);
      exp_q.push_back(c + 24);
      exp_q.push_back(c + 33);
      exp_q.push_back(c + 35);
      exp_q.push_back(c + 37);
      exp_q.push_back(c + 39);
      exp_q.push_back(c + 48);
      rst = 1'b0;
      expect_at("t1_pre", c + 7, 0, 1);
      expect_at("t1_rise", c + 8, 1, 1);
      expect_at("t1_high", c + 15, 1, 1);
      expect_at("t1_fall", c + 16, 0, 1);

      // 2: rate change mid high phase, then back to base rate
      wait_to(c + 28);
      rate_sel = 2'd3;
      expect_at("t2_hold", c + 31, 1, 1);
      expect_at("t2_fall", c + 32, 0, 1);
      expect_at("t2_fast_hi", c + 33, 1, 1);
      expect_at("t2_fast_lo", c + 34, 0, 1);
      wait_to(c + 39);
      rate_sel = 2'd0;
      d = c + 40;
      expect_at("t2_slow_lo", d + 7, 0, 1);

      // 3: short run press is rejected, long press stops at the next fall
      wait_to(d + 1);
      key_run = 1'b0;
      wait_to(d + 4);
      key_run = 1'b1;
      expect_at("t3_short", d + 8, 1, 1);
      wait_to(d + 10);
      key_run = 1'b0;
      exp_q.push_back(d + 24);
      wait_to(d + 20);
      key_run = 1'b1;
      expect_at("t3_stopping", d + 31, 1, 1);
      expect_at("t3_stopped", d + 32, 0, 0);
      e = d + 40;
      expect_at("t3_held", e, 0, 0);

      // 4: two single steps while stopped
      exp_q.push_back(e + 7);
      key_step = 1'b0;
      expect_at("t4_pre", e + 6, 0, 0);
      expect_at("t4_step", e + 7, 1, 0);
      wait_to(e + 8);
      key_step = 1'b1;
      expect_at("t4_high", e + 14, 1, 0);
      expect_at("t4_end", e + 15, 0, 0);
      exp_q.push_back(e + 27);
      wait_to(e + 20);
      key_step = 1'b0;
      expect_at("t4_step2", e + 27, 1, 0);
      wait_to(e + 28);
      key_step = 1'b1;
      expect_at("t4_high2", e + 34, 1, 0);
      expect_at("t4_end2", e + 35, 0, 0);
      f = e + 45;
      expect_at("t4_held", f, 0, 0);

      // 5: simultaneous run and step: run wins
      exp_q.push_back(f + 15);
      key_run  = 1'b0;
      key_step = 1'b0;
      expect_at("t5_resume", f + 7, 0, 1);
      wait_to(f + 8);
      key_run  = 1'b1;
      key_step = 1'b1;
      expect_at("t5_nostep", f + 8, 0, 1);
      expect_at("t5_pre", f + 14, 0, 1);
      expect_at("t5_rise", f + 15, 1, 1);

      // 6b: reset during the STOPPING high phase
      exp_q.push_back(f + 31);
      wait_to(f + 20);
      key_run = 1'b0;
      wait_to(f + 28);
      key_run = 1'b1;
      expect_at("t6b_high", f + 31, 1, 1);
      wait_to(f + 33);
      rst = 1'b1;
      expect_at("t6b_rst", f + 34, 0, 1);
      chk("t6b_rst_tick", int'(tick), 0);
      wait_to(f + 35);
      rst = 1'b0;
      g = f + 35;
      exp_q.push_back(g + 8);
      exp_q.push_back(g + 24);
      expect_at("t6b_pre", g + 7, 0, 1);
      expect_at("t6b_rise", g + 8, 1, 1);

      // 6a: stop, step, then reset during the step
      wait_to(g + 12);
      key_run = 1'b0;
      wait_to(g + 20);
      key_run = 1'b1;
      expect_at("t6a_stopped", g + 32, 0, 0);
      wait_to(g + 34);
      key_step = 1'b0;
      exp_q.push_back(g + 41);
      expect_at("t6a_step", g + 41, 1, 0);
      wait_to(g + 42);
      key_step = 1'b1;
      wait_to(g + 44);
      rst = 1'b1;
      expect_at("t6a_rst", g + 45, 0, 1);
      chk("t6a_rst_tick", int'(tick), 0);
      wait_to(g + 46);
      rst = 1'b0;
      h = g + 46;
      exp_q.push_back(h + 8);
      expect_at("t6a_pre", h + 7, 0, 1);
      expect_at("t6a_rise", h + 8, 1, 1);

      wait_to(h + 12);
      chk("ticks_outstanding", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
